sm_ifetch: RTL
==============

SM_IFETCH -- requirements
Module: sm_ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the byte address of the first fetched instruction after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, the instruction-queue depth; legal values are powers of two, 2..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port imAddr, output, 32 bits: word index to instruction memory, equal to {2'b00, fetch_pc[31:2]}.
REQ-006 SHALL have port imData, input, 32 bits: instruction word returned combinationally, in the same cycle, for imAddr.
REQ-007 SHALL have port redirect, input, 1 bit: branch/jump taken; flush and restart fetch.
REQ-008 SHALL have port redirect_pc, input, 32 bits: new byte address, valid when redirect=1.
REQ-009 SHALL have port out_valid, output, 1 bit: out_instr/out_pc hold a valid entry.
REQ-010 SHALL have port out_ready, input, 1 bit: the decode stage accepts the entry this cycle.
REQ-011 SHALL have port out_instr, output, 32 bits: head-of-queue instruction.
REQ-012 SHALL have port out_pc, output, 32 bits: byte address of out_instr.

Function
REQ-013 SHALL hold fetch_pc, a 32-bit byte address that is always word-aligned.
REQ-014 SHALL push {fetch_pc, imData} into the queue and advance fetch_pc by 4 on every cycle where push is enabled; push is enabled when redirect=0 and the queue is either not full or pops this cycle.
REQ-015 SHALL pop the head entry on every cycle where out_valid=1 and out_ready=1.
REQ-016 SHALL allow a push and a pop in the same cycle, including when the queue is full; occupancy is unchanged in that case.
REQ-017 SHALL hold fetch_pc and keep imAddr stable when the queue is full and no pop occurs.
REQ-018 SHALL, when redirect=1, flush all queue entries, ignore that cycle's push and pop, and load fetch_pc with {redirect_pc[31:2], 2'b00} (low bits forced to zero).
REQ-019 SHALL drive out_valid=0 in the cycle after a redirect; the first redirected instruction is valid one cycle later.
REQ-020 SHALL wrap fetch_pc modulo 2^32 (32'hFFFF_FFFC + 4 -> 32'h0000_0000).
REQ-021 SHALL drive out_valid as (occupancy != 0), with out_instr and out_pc taken combinationally from the head entry.
REQ-022 SHALL keep out_instr and out_pc stable while out_valid=1 and out_ready=0.
REQ-023 SHALL have a latency of 1 cycle from push to out_valid; throughput SHALL be 1 instruction per cycle under continuous out_ready=1.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously set fetch_pc=RESET_PC, occupancy=0, and queue pointers=0.
REQ-025 SHALL, during reset, drive out_valid=0, out_instr=0, out_pc=0, and imAddr={2'b00, RESET_PC[31:2]}.
REQ-026 SHALL, on reset asserted mid-operation, discard all queued entries immediately; no entry survives reset.
REQ-027 SHALL push on the first rising clk edge after rst_n deasserts, giving out_valid=1 with out_pc=RESET_PC.

Structure
REQ-028 SHALL place ILEN=32 and the default RESET_PC constant in the shared package sm_ifetch_pkg, together with a packed struct sm_ifq_entry_t {pc, instr}.
REQ-029 SHALL implement the queue as the sub-module sm_ifq, a synchronous FIFO with flush, push/pop, full/empty, and pointers of log2(QDEPTH)+1 bits.
REQ-030 SHALL keep the PC register, push/pop control and redirect logic in sm_ifetch, at 120-400 RTL lines in total.

Verification
REQ-031 SHALL cover reset release with RESET_PC=0, memory word n = 32'h1000_0000+n, and out_ready=1 -> out_pc sequence 0,4,8,... one per cycle, out_instr 32'h1000_0000, 32'h1000_0001, ...
REQ-032 SHALL cover backpressure: out_ready=0 for 5 cycles with QDEPTH=2 -> occupancy saturates at 2, imAddr holds at 2, out_pc holds at 0; out_ready=1 then resumes without loss or duplication.
REQ-033 SHALL cover redirect=1 with redirect_pc=32'h0000_0043 while the queue is full -> next cycle out_valid=0 and imAddr=32'h10; the following cycle out_pc=32'h40.
REQ-034 SHALL cover wrap-around with RESET_PC=32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 SHALL cover rst_n pulsed low asynchronously mid-cycle with 2 entries queued -> out_valid drops immediately without a clock edge, and fetch restarts at RESET_PC.
REQ-036 SHALL cover random out_ready with a scoreboard over 10,000 cycles -> out_pc strictly sequential (+4) between redirects, with no drops or duplicates.

Source files
------------

// File: rtl/sm_ifetch_pkg.sv
// Shared constants and the queue entry layout for the instruction-fetch slice.
package sm_ifetch_pkg;

    localparam int          ILEN             = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]     pc;
        logic [ILEN-1:0] instr;
    } sm_ifq_entry_t;

    // Byte addresses handed to fetch are always forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/sm_ifq.sv
// Synchronous instruction FIFO with flush; pointers carry one wrap bit so full
// and empty are distinguishable without a separate counter.
module sm_ifq
    import sm_ifetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  sm_ifq_entry_t push_data,
    input  logic          pop,
    output sm_ifq_entry_t head,
    output logic          full,
    output logic          empty
);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;
    sm_ifq_entry_t mem [DEPTH];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sm_ifetch.sv
// Instruction fetch: sequential PC, same-cycle instruction memory read, and a
// small queue towards decode that is flushed on redirect.
module sm_ifetch
    import sm_ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [31:0]     imAddr,
    input  logic [ILEN-1:0] imData,
    input  logic            redirect,
    input  logic [31:0]     redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [31:0]     out_pc
);

    // Decode handshake: an entry transfers on a rising edge where out_valid and
    // out_ready are both high; out_valid never depends on out_ready, and the
    // presented entry stays put until it transfers or a redirect flushes it.

    logic [31:0]   fetch_pc;
    logic          q_full;
    logic          q_empty;
    logic          push_en;
    logic          pop_en;
    sm_ifq_entry_t push_entry;
    sm_ifq_entry_t head;

    assign imAddr = {2'b00, fetch_pc[31:2]};

    // Redirect overrides both sides of the queue for that cycle.
    assign pop_en  = out_valid && out_ready && !redirect;
    assign push_en = !redirect && (!q_full || pop_en);

    assign push_entry.pc    = fetch_pc;
    assign push_entry.instr = imData;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= word_align(RESET_PC);
        end else if (redirect) begin
            fetch_pc <= word_align(redirect_pc);
        end else if (push_en) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    sm_ifq #(
        .DEPTH (QDEPTH)
    ) u_ifq (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push_en),
        .push_data (push_entry),
        .pop       (pop_en),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Outputs read as zero whenever nothing valid is held, including in reset.
    assign out_valid = !q_empty;
    assign out_instr = out_valid ? head.instr : '0;
    assign out_pc    = out_valid ? head.pc    : '0;

endmodule
